// File: rtl/addr_multicycle_pkg.sv
// Shared types and default sizing for the multi-cycle chunked adder.
package addr_multicycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/addr_multicycle_cla_chunk.sv
// cla_chunk: combinational W-bit carry-lookahead adder slice.
// Each carry is built directly from generate/propagate terms and the slice carry-in.
module cla_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;

    // Carry into bit n as the sum-of-products lookahead expression.
    function automatic logic lookahead(input logic [W-1:0] g, input logic [W-1:0] p,
                                       input logic c0, input int n);
        logic c;
        logic term;
        term = c0;
        for (int k = 0; k < n; k++) term = term & p[k];
        c = term;
        for (int j = 0; j < n; j++) begin
            term = g[j];
            for (int k = j + 1; k < n; k++) term = term & p[k];
            c = c | term;
        end
        return c;
    endfunction

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_c = '0;
        for (int i = 0; i <= W; i++) w_c[i] = lookahead(w_g, w_p, cin, i);
    end

    assign s     = w_p ^ w_c[W-1:0];
    assign cout  = w_c[W];
    assign c_msb = w_c[W-1];

endmodule

// File: rtl/addr_multicycle.sv
// Multi-cycle adder: one CHUNK-bit lookahead slice reused over WIDTH/CHUNK cycles.
// Optional subtract select is compiled in when ADDR_SUB_EN is defined.
module addr_multicycle
    import addr_multicycle_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADDR_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_cfg
        $error("addr_multicycle: WIDTH must be a positive multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic [CHUNK-1:0]   w_s;
    logic               w_cout;
    logic               w_cmsb;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_last;

`ifdef ADDR_SUB_EN
    assign w_b_in = op_sub ? ~b : b;
`else
    assign w_b_in = b;
`endif

    cla_chunk #(.W(CHUNK)) u_cla (
        .a     (r_a[int'(r_idx) * CHUNK +: CHUNK]),
        .b     (r_b[int'(r_idx) * CHUNK +: CHUNK]),
        .cin   (r_carry),
        .s     (w_s),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    assign w_last = (r_idx == LAST_IDX);

    always_comb begin
        w_result = r_acc;
        w_result[int'(r_idx) * CHUNK +: CHUNK] = w_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_BUSY;
            end
            ST_BUSY: if (w_last) w_next = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Control and visible result: cleared by reset, result only updated on the final chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (in_valid) begin
                r_idx   <= '0;
                r_carry <= c_in;
            end
        end else if (r_state == ST_BUSY) begin
            r_idx   <= r_idx + 1'b1;
            r_carry <= w_cout;
            if (w_last) begin
                r_sum  <= w_result;
                r_cout <= w_cout;
                r_ovf  <= w_cmsb ^ w_cout;
                r_zero <= (w_result == '0);
            end
        end
    end

    // Operand capture and partial sum; no reset needed since results gate on state.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_valid) begin
            r_a <= a;
            r_b <= w_b_in;
        end
        if (r_state == ST_BUSY) r_acc <= w_result;
    end

    assign sum   = r_sum;
    assign c_out = r_cout;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule

// File: tb/tb_addr_multicycle.sv
// Directed bench for addr_multicycle at default WIDTH=32, CHUNK=8.
module tb_addr_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int n_total = 0;
    int n_pass  = 0;

    addr_multicycle dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef ADDR_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic icin, input logic isub, input int hold,
                          input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        int lat;
        logic stable;
        a = ia; b = ib; c_in = icin; op_sub = isub; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check({name, ".busy_in_ready"}, 64'(in_ready), 64'd0);
        // Scramble operands and keep in_valid high: both must be ignored while busy.
        a = ~ia; b = ia ^ ib; c_in = ~icin; op_sub = ~isub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, ".latency"}, 64'(lat), 64'd4);
        check({name, ".sum"}, 64'(sum), 64'(es));
        check({name, ".c_out"}, 64'(c_out), 64'(ec));
        check({name, ".ovf"}, 64'(ovf), 64'(eo));
        check({name, ".zero"}, 64'(zero), 64'(ez));
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (!(out_valid === 1'b1 && in_ready === 1'b0 && sum === es &&
                      c_out === ec && ovf === eo && zero === ez)) stable = 1'b0;
            end
            check({name, ".hold_stable"}, 64'(stable), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".back_idle"}, 64'({in_ready, out_valid}), 64'b10);
        check({name, ".sum_kept"}, 64'(sum), 64'(es));
    endtask

    initial begin
        bit no_valid;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
        tick();
        tick();
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.outs", 64'({sum, c_out, ovf, zero}), 64'd0);
        rst_n = 1'b1;
        tick();
        check("reset.in_ready", 64'(in_ready), 64'd1);

        run_op("add5_3",   32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 10, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        run_op("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0,  32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("posovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0,  32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("negovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0,  32'h0000_0000, 1'b1, 1'b1, 1'b1);
        run_op("mixed",    32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 2,  32'hACF1_3568, 1'b0, 1'b0, 1'b0);

        // Abort mid-operation with idx=2: accept edge, then two chunk cycles.
        a = 32'h0000_0001; b = 32'h0000_0001; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.outs", 64'({sum, c_out, ovf, zero}), 64'd0);
        no_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) no_valid = 1'b0;
        end
        check("abort.no_result", 64'(no_valid), 64'd1);
        run_op("after_abort", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 0, 32'h0000_0101, 1'b0, 1'b0, 1'b0);

`ifdef ADDR_SUB_EN
        run_op("sub3_5", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
